// File: rtl/booth_acc_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// booth_acc_stage : saturating block accumulator for signed Booth products
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module booth_acc_stage #(
  parameter int PW = 16,
  parameter int AW = 24,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [CW-1:0] len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_acc,
  output logic          out_sat
);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic          sat_q, sat_d;
  logic [AW-1:0] out_acc_q, out_acc_d;
  logic          out_sat_q, out_sat_d;

  logic [AW:0]   sum;
  logic [AW-1:0] acc_clamped;
  logic          sat_new;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] len_eff;

  // One guard bit is enough: AW > PW, so the AW+1 sum cannot wrap.
  always_comb begin
    sum         = {{(AW+1-PW){in_prod[PW-1]}}, in_prod} + {acc_q[AW-1], acc_q};
    acc_clamped = sum[AW-1:0];
    sat_new     = sat_q;
    if (sum[AW] != sum[AW-1]) begin
      acc_clamped = sum[AW] ? ACC_MIN : ACC_MAX;
      sat_new     = 1'b1;
    end
    cnt_inc = cnt_q + CW'(1);
    len_eff = len_q;
    if (cnt_q == '0) begin
      len_eff = (len == '0) ? CW'(1) : len;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    sat_d     = sat_q;
    out_acc_d = out_acc_q;
    out_sat_d = out_sat_q;
    if (clr) begin
      state_d   = ST_ACC;
      acc_d     = '0;
      cnt_d     = '0;
      len_d     = '0;
      sat_d     = 1'b0;
      out_acc_d = '0;
      out_sat_d = 1'b0;
    end else if (state_q == ST_ACC) begin
      if (in_valid) begin
        acc_d = acc_clamped;
        sat_d = sat_new;
        cnt_d = cnt_inc;
        len_d = len_eff;
        if (cnt_inc == len_eff) begin
          state_d   = ST_HOLD;
          out_acc_d = acc_clamped;
          out_sat_d = sat_new;
        end
      end
    end else begin
      if (out_ready) begin
        state_d = ST_ACC;
        acc_d   = '0;
        cnt_d   = '0;
        sat_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      sat_q     <= 1'b0;
      out_acc_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      sat_q     <= sat_d;
      out_acc_q <= out_acc_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign out_acc   = out_acc_q;
  assign out_sat   = out_sat_q;

endmodule
`default_nettype wire
